pc_unit_ras: RTL and testbench

//  Parametrised program-counter unit for the multi-cycle MIPS datapath.

---
 rtl/pc_unit_ras.sv | 144 ++++++++++++++
 tb/tb_pc_unit_ras.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: program-counter unit for the multi-cycle MIPS datapath.
// Holds the PC and selects the next PC from sequential, branch, jump or
// register sources. A circular return-address stack serves jal/jr $ra
// pairs, and a RUN/HALT state machine gates all updates.
// Optional feature macro: PC_ALIGN_CHECK_EN (traps misaligned targets to
// TRAP_ADDR and reports them on addrErr/epc).
module pc_unit_ras #(
  parameter int            AW         = 32,
  parameter logic [AW-1:0] RESET_ADDR = AW'(32'h00003000),
  parameter int            RAS_DEPTH  = 4,
  parameter logic [AW-1:0] TRAP_ADDR  = AW'(32'h00004180)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PCWre,
  input  logic          halt,
  input  logic          resume,
  input  logic [1:0]    pcSrc,
  input  logic          branchTaken,
  input  logic [15:0]   imm16,
  input  logic [25:0]   jTarget,
  input  logic [AW-1:0] regTarget,
  input  logic          call,
  input  logic          ret,
  output logic [AW-1:0] currentIAddr,
  output logic [AW-1:0] pcPlus4,
  output logic          halted,
  output logic          rasEmpty,
  output logic          rasFull,
  output logic          addrErr,
  output logic [AW-1:0] epc
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] ptr;      // next free slot; top of stack is ptr-1
  logic [CW-1:0] cnt;
  logic [PW-1:0] top_idx;
  logic [AW-1:0] ras_top;
  logic [AW-1:0] tgt_raw;
  logic [AW-1:0] pc_upd;
  logic          update;
  logic          ras_en;
  logic          push;
  logic          pop;
  logic          replace;

  // Branch offset in bytes: sign-extended word offset shifted left by two.
  function automatic logic signed [AW-1:0] branch_off(input logic [15:0] imm);
    return {{(AW-18){imm[15]}}, imm, 2'b00};
  endfunction

  assign currentIAddr = pc;
  assign pcPlus4      = pc + AW'(4);
  assign halted       = (state == HALT);
  assign rasEmpty     = (cnt == '0);
  assign rasFull      = (cnt == CW'(RAS_DEPTH));
  assign top_idx      = ptr - PW'(1);
  assign ras_top      = stack[top_idx];

  // A halt request on a RUN edge takes effect instead of the PC update.
  assign update = (state == RUN) && PCWre && !halt;

  // Raw next-PC selection; a return overrides the pcSrc select.
  always_comb begin
    tgt_raw = pcPlus4;
    if (ret) begin
      tgt_raw = rasEmpty ? regTarget : ras_top;
    end else begin
      case (pcSrc)
        2'b01: if (branchTaken) tgt_raw = pcPlus4 + $unsigned(branch_off(imm16));
        2'b10: tgt_raw[27:0] = {jTarget, 2'b00};
        2'b11: tgt_raw = regTarget;
        default: tgt_raw = pcPlus4;
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = (tgt_raw[1:0] != 2'b00);
  assign pc_upd   = misalign ? TRAP_ADDR : tgt_raw;
  // A trapped target must not disturb the return stack.
  assign ras_en   = update && !misalign;

  // One-cycle fault pulse and capture of the offending target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrErr <= 1'b0;
      epc     <= '0;
    end else begin
      addrErr <= update && misalign;
      if (update && misalign) epc <= tgt_raw;
    end
  end
`else
  assign pc_upd  = tgt_raw & ~AW'(3);
  assign ras_en  = update;
  assign addrErr = 1'b0;
  assign epc     = '0;
`endif

  // call&ret on a non-empty stack rewrites the top entry in place.
  assign push    = ras_en && call && (!ret || rasEmpty);
  assign pop     = ras_en && ret && !call;
  assign replace = ras_en && call && ret && !rasEmpty;

  // Run/halt state, PC register and stack bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      pc    <= RESET_ADDR;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        RUN:     if (halt) state <= HALT;
        HALT:    if (!halt && resume) state <= RUN;
        default: state <= RUN;
      endcase
      if (update) pc <= pc_upd;
      if (push) begin
        ptr <= ptr + PW'(1);
        if (!rasFull) cnt <= cnt + CW'(1);
      end else if (pop && !rasEmpty) begin
        ptr <= ptr - PW'(1);
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Stack storage; a push when full lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (push) stack[ptr] <= pcPlus4;
    else if (replace) stack[top_idx] <= pcPlus4;
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed bench for pc_unit_ras with a scoreboard of
// expected per-cycle results and a reference return-stack model.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWre, halt, resume, branchTaken, call, ret;
  logic [1:0]  pcSrc;
  logic [15:0] imm16;
  logic [25:0] jTarget;
  logic [31:0] regTarget;
  logic [31:0] currentIAddr, pcPlus4, epc;
  logic        halted, rasEmpty, rasFull, addrErr;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        hl;
    logic        ae;
    logic [31:0] ep;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ras_model[$];
  logic [31:0] lnk;

  pc_unit_ras dut (
    .clk(clk), .rst(rst), .PCWre(PCWre), .halt(halt), .resume(resume),
    .pcSrc(pcSrc), .branchTaken(branchTaken), .imm16(imm16),
    .jTarget(jTarget), .regTarget(regTarget), .call(call), .ret(ret),
    .currentIAddr(currentIAddr), .pcPlus4(pcPlus4), .halted(halted),
    .rasEmpty(rasEmpty), .rasFull(rasFull), .addrErr(addrErr), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every observable against one popped expectation.
  task automatic check_all(input exp_t e);
    chk({e.tag, ".pc"},     currentIAddr, e.pc);
    chk({e.tag, ".pc4"},    pcPlus4, e.pc + 32'd4);
    chk({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.hl});
    chk({e.tag, ".empty"},  {31'd0, rasEmpty}, {31'd0, ras_model.size() == 0});
    chk({e.tag, ".full"},   {31'd0, rasFull}, {31'd0, ras_model.size() == 4});
    chk({e.tag, ".aerr"},   {31'd0, addrErr}, {31'd0, e.ae});
    chk({e.tag, ".epc"},    epc, e.ep);
  endtask

  // Queue the expected post-edge state, clock once, then pop and compare.
  task automatic tick(input string tag, input logic [31:0] pc_e, input logic hl_e = 1'b0,
                      input logic ae_e = 1'b0, input logic [31:0] ep_e = 32'h0);
    exp_q.push_back('{tag: tag, pc: pc_e, hl: hl_e, ae: ae_e, ep: ep_e});
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else check_all(exp_q.pop_front());
  endtask

  task automatic model_push(input logic [31:0] v);
    ras_model.push_back(v);
    if (ras_model.size() > 4) void'(ras_model.pop_front());
  endtask

  initial begin
    rst = 1'b0; PCWre = 1'b0; halt = 1'b0; resume = 1'b0; pcSrc = 2'b00;
    branchTaken = 1'b0; imm16 = '0; jTarget = '0; regTarget = '0;
    call = 1'b0; ret = 1'b0;
    #12;
    check_all('{tag: "reset", pc: 32'h3000, hl: 1'b0, ae: 1'b0, ep: 32'h0});
    @(posedge clk); #1; rst = 1'b1;

    // T1: sequential fetch
    PCWre = 1'b1;
    tick("t1a", 32'h3004); tick("t1b", 32'h3008); tick("t1c", 32'h300C);
    tick("t1d", 32'h3010);
    // T2: branch taken backwards, then not taken, then stall
    pcSrc = 2'b01; branchTaken = 1'b1; imm16 = 16'hFFFC;
    tick("t2tk", 32'h3004);
    pcSrc = 2'b00;
    tick("t2s0", 32'h3008); tick("t2s1", 32'h300C); tick("t2s2", 32'h3010);
    pcSrc = 2'b01; branchTaken = 1'b0;
    tick("t2nt", 32'h3014);
    PCWre = 1'b0; pcSrc = 2'b00;
    tick("t2hold", 32'h3014);
    PCWre = 1'b1;
    // T3: call via jump, then return
    pcSrc = 2'b11; regTarget = 32'h3000;
    tick("t3jr", 32'h3000);
    pcSrc = 2'b10; jTarget = 26'h0000C40; call = 1'b1; model_push(32'h3004);
    tick("t3call", 32'h3100);
    pcSrc = 2'b00; call = 1'b0; ret = 1'b1; void'(ras_model.pop_back());
    tick("t3ret", 32'h3004);
    // T4: overflow with five calls, four returns, then empty return
    ret = 1'b0; call = 1'b1; pcSrc = 2'b11;
    for (int i = 0; i < 5; i++) begin
      model_push(currentIAddr + 32'd4);
      regTarget = 32'h5000 + 32'h100 * i;
      tick("t4call", regTarget);
    end
    call = 1'b0; ret = 1'b1; pcSrc = 2'b00; regTarget = 32'h3200;
    for (int i = 0; i < 4; i++) begin
      lnk = ras_model.pop_back();
      tick("t4ret", lnk);
    end
    tick("t4retempty", 32'h3200);
    // call & ret: empty -> push, then replace top
    call = 1'b1; regTarget = 32'h3300; model_push(32'h3204);
    tick("t4cr0", 32'h3300);
    ras_model[ras_model.size()-1] = 32'h3304;
    tick("t4cr1", 32'h3204);
    call = 1'b0; void'(ras_model.pop_back());
    tick("t4cr2", 32'h3304);
    // T5: halt, hold, resume, reset during halt
    ret = 1'b0; pcSrc = 2'b11; regTarget = 32'h3004;
    tick("t5set", 32'h3004);
    pcSrc = 2'b00; call = 1'b1; model_push(32'h3008);
    tick("t5push", 32'h3008);
    halt = 1'b1;
    tick("t5halt", 32'h3008, 1'b1);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) tick("t5hold", 32'h3008, 1'b1);
    halt = 1'b1; resume = 1'b1;
    tick("t5prio", 32'h3008, 1'b1);
    halt = 1'b0; call = 1'b0;
    tick("t5resume", 32'h3008, 1'b0);
    resume = 1'b0;
    tick("t5run", 32'h300C);
    halt = 1'b1;
    tick("t5halt2", 32'h300C, 1'b1);
    halt = 1'b0;
    #2 rst = 1'b0; #1;
    ras_model.delete();
    check_all('{tag: "t5rst", pc: 32'h3000, hl: 1'b0, ae: 1'b0, ep: 32'h0});
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    // T6: misaligned register target
    pcSrc = 2'b11; regTarget = 32'h3006;
`ifdef PC_ALIGN_CHECK_EN
    tick("t6trap", 32'h4180, 1'b0, 1'b1, 32'h3006);
    pcSrc = 2'b00;
    tick("t6after", 32'h4184, 1'b0, 1'b0, 32'h3006);
`else
    tick("t6mask", 32'h3004);
    pcSrc = 2'b00;
    tick("t6after", 32'h3008);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
